// File: rtl/button_event_controller_if.sv
// AHB-Lite bus bundle for the button event controller.
// The master modport is the bus side; the slave modport is the peripheral side.
interface button_event_controller_if;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic        HREADY;
    logic        HSEL;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic [31:0] HRDATA;
    logic        HREADYOUT;

    modport master (
        output HADDR, HWDATA, HWRITE, HREADY, HSEL, HSIZE, HTRANS,
        input  HRDATA, HREADYOUT
    );

    modport slave (
        input  HADDR, HWDATA, HWRITE, HREADY, HSEL, HSIZE, HTRANS,
        output HRDATA, HREADYOUT
    );
endinterface

// File: rtl/button_event_controller.sv
// AHB-Lite slave: debounces NUM_BTN active-low buttons and latches short/long/combo events.
// Define BTN_IRQ_EN to add the IRQ output and the IRQ_EN register at 0x10.
module button_event_controller #(
    parameter int unsigned NUM_BTN     = 2,
    parameter int unsigned DEB_CYCLES  = 900,
    parameter int unsigned HOLD_CYCLES = 16000
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    button_event_controller_if.slave bus,
    input  logic [NUM_BTN-1:0]       nBtn
`ifdef BTN_IRQ_EN
    ,
    output logic                     IRQ
`endif
);
    localparam int unsigned DebW  = $clog2(DEB_CYCLES + 1);
    localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);
    localparam logic [DebW-1:0]  DebLast  = DebW'(DEB_CYCLES - 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StPressed, StHeld} btn_state_e;

    logic [NUM_BTN-1:0] sync1_q, sync2_q;
    logic [NUM_BTN-1:0] d_q, d_d, fall, rise;
    logic [DebW-1:0]    deb_cnt_q [NUM_BTN];
    logic [DebW-1:0]    deb_cnt_d [NUM_BTN];
    btn_state_e         state_q   [NUM_BTN];
    btn_state_e         state_d   [NUM_BTN];
    logic [HoldW-1:0]   hold_q    [NUM_BTN];
    logic [HoldW-1:0]   hold_d    [NUM_BTN];
    logic [NUM_BTN-1:0] busy, others, short_set, long_set;
    logic               combo_trig, suppress, combo_lock_q, combo_lock_d;
    logic [NUM_BTN-1:0] short_q, short_d, short_clr, long_q, long_d, long_clr;
    logic               combo_q, combo_d, combo_clr, any_flag;
    logic               addr_ok, acc_q, wr_q, rd, wr;
    logic [2:0]         addr_q;
    logic [31:0]        rdata;
    logic               unused_bus;

    // Debounce: d toggles once s has differed from it for DEB_CYCLES consecutive cycles.
    always_comb begin
        d_d  = d_q;
        fall = '0;
        rise = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            deb_cnt_d[i] = '0;
            if (sync2_q[i] != d_q[i]) begin
                if (deb_cnt_q[i] == DebLast) begin
                    d_d[i]  = sync2_q[i];
                    fall[i] = d_q[i];
                    rise[i] = ~d_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        busy       = '0;
        others     = '0;
        combo_trig = 1'b0;
        for (int i = 0; i < NUM_BTN; i++) begin
            busy[i] = (state_q[i] != StIdle);
        end
        for (int i = 0; i < NUM_BTN; i++) begin
            others    = busy | fall;
            others[i] = 1'b0;
            if (fall[i] && (others != '0)) combo_trig = 1'b1;
        end
        suppress     = combo_lock_q | combo_trig;
        combo_lock_d = combo_trig | (combo_lock_q & (busy != '0));
    end

    always_comb begin
        short_set = '0;
        long_set  = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            state_d[i] = state_q[i];
            hold_d[i]  = hold_q[i];
            case (state_q[i])
                StIdle: begin
                    if (fall[i]) begin
                        state_d[i] = StPressed;
                        hold_d[i]  = '0;
                    end
                end
                StPressed: begin
                    // A release on the same cycle the hold limit is reached counts as short.
                    if (rise[i]) begin
                        state_d[i]   = StIdle;
                        hold_d[i]    = '0;
                        short_set[i] = ~suppress;
                    end else if (hold_q[i] == HoldLast) begin
                        state_d[i]  = StHeld;
                        long_set[i] = ~suppress;
                    end else begin
                        hold_d[i] = hold_q[i] + 1'b1;
                    end
                end
                StHeld: begin
                    if (rise[i]) begin
                        state_d[i] = StIdle;
                        hold_d[i]  = '0;
                    end
                end
                default: state_d[i] = StIdle;
            endcase
        end
    end

    assign addr_ok = bus.HSEL && bus.HREADY && (bus.HTRANS != 2'b00);
    assign rd      = acc_q & ~wr_q;
    assign wr      = acc_q & wr_q;

    // Read-to-clear drops exactly the bits returned; W1C uses data-phase HWDATA; sets win.
    always_comb begin
        short_clr = '0;
        long_clr  = '0;
        combo_clr = 1'b0;
        if (rd) begin
            unique case (addr_q)
                3'd0:    short_clr = short_q;
                3'd1:    long_clr  = long_q;
                3'd2:    combo_clr = combo_q;
                default: ;
            endcase
        end else if (wr) begin
            unique case (addr_q)
                3'd0:    short_clr = bus.HWDATA[NUM_BTN-1:0];
                3'd1:    long_clr  = bus.HWDATA[NUM_BTN-1:0];
                3'd2:    combo_clr = bus.HWDATA[0];
                default: ;
            endcase
        end
        short_d = (short_q & ~short_clr) | short_set;
        long_d  = (long_q & ~long_clr) | long_set;
        combo_d = (combo_q & ~combo_clr) | combo_trig;
    end

    assign any_flag = (|short_q) | (|long_q) | combo_q;

`ifdef BTN_IRQ_EN
    logic [2:0] irq_en_q;
    logic       irq_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            irq_en_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            if (wr && addr_q == 3'd4) irq_en_q <= bus.HWDATA[2:0];
            irq_q <= ((|short_q) & irq_en_q[0]) | ((|long_q) & irq_en_q[1]) |
                     (combo_q & irq_en_q[2]);
        end
    end

    assign IRQ = irq_q;
`endif

    always_comb begin
        rdata = '0;
        if (rd) begin
            unique case (addr_q)
                3'd0: rdata[NUM_BTN-1:0] = short_q;
                3'd1: rdata[NUM_BTN-1:0] = long_q;
                3'd2: rdata[0] = combo_q;
                3'd3: begin
                    rdata[0]            = any_flag;
                    rdata[8 +: NUM_BTN] = ~d_q;
                end
`ifdef BTN_IRQ_EN
                3'd4: rdata[2:0] = irq_en_q;
`endif
                default: ;
            endcase
        end
    end

    assign bus.HRDATA    = rdata;
    assign bus.HREADYOUT = 1'b1;
    assign unused_bus    = ^{bus.HSIZE, bus.HADDR, bus.HWDATA};

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sync1_q      <= '1;
            sync2_q      <= '1;
            d_q          <= '1;
            combo_lock_q <= 1'b0;
            short_q      <= '0;
            long_q       <= '0;
            combo_q      <= 1'b0;
            acc_q        <= 1'b0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                deb_cnt_q[i] <= '0;
                state_q[i]   <= StIdle;
                hold_q[i]    <= '0;
            end
        end else begin
            sync1_q      <= nBtn;
            sync2_q      <= sync1_q;
            d_q          <= d_d;
            combo_lock_q <= combo_lock_d;
            short_q      <= short_d;
            long_q       <= long_d;
            combo_q      <= combo_d;
            acc_q        <= addr_ok;
            wr_q         <= addr_ok & bus.HWRITE;
            addr_q       <= addr_ok ? bus.HADDR[4:2] : 3'd0;
            for (int i = 0; i < NUM_BTN; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
                state_q[i]   <= state_d[i];
                hold_q[i]    <= hold_d[i];
            end
        end
    end
endmodule

// File: tb/tb_button_event_controller.sv
// Randomised bench for button_event_controller with a press-duration reference model,
// plus directed scenarios with literal expectations. Honours BTN_IRQ_EN when defined.
module tb_button_event_controller;
    localparam int NB   = 3;
    localparam int DEB  = 4;
    localparam int HOLD = 20;

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic [NB-1:0] nBtn;
    logic          irq;
    int            n_cmp = 0;
    int            n_fail = 0;
    bit            check_en = 1'b0;

    button_event_controller_if bus ();

    button_event_controller #(
        .NUM_BTN    (NB),
        .DEB_CYCLES (DEB),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .HCLK   (HCLK),
        .HRESETn(HRESETn),
        .bus    (bus),
        .nBtn   (nBtn)
`ifdef BTN_IRQ_EN
        ,
        .IRQ    (irq)
`endif
    );

`ifndef BTN_IRQ_EN
    assign irq = 1'b0;
`endif

    always #5 HCLK = ~HCLK;

    // Reference model: sync pipe, per-channel history window and press age.
    logic [NB-1:0] m_p0, m_p1, m_d, m_short, m_long;
    bit            m_hist [NB][DEB];
    bit            m_pressed [NB];
    bit            m_long_done [NB];
    int            m_age [NB];
    bit            m_lock, m_combo, m_acc, m_wr, m_irq;
    int            m_addr;
    logic [2:0]    m_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_p0 = '1; m_p1 = '1; m_d = '1; m_short = '0; m_long = '0;
        m_lock = 0; m_combo = 0; m_acc = 0; m_wr = 0; m_addr = 0; m_en = '0; m_irq = 0;
        for (int i = 0; i < NB; i++) begin
            m_pressed[i] = 0; m_long_done[i] = 0; m_age[i] = 0;
            for (int k = 0; k < DEB; k++) m_hist[i][k] = 1;
        end
    endtask

    task automatic model_step();
        logic [NB-1:0] fall, rise, sset, lset, sclr, lclr;
        bit all_diff, trig, supp, any_busy, cclr;
        int n_other;
        fall = '0; rise = '0; sset = '0; lset = '0; sclr = '0; lclr = '0; cclr = 0;
        for (int i = 0; i < NB; i++) begin
            for (int k = DEB - 1; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
            m_hist[i][0] = m_p1[i];
            all_diff = 1;
            for (int k = 0; k < DEB; k++) if (m_hist[i][k] == m_d[i]) all_diff = 0;
            fall[i] = all_diff && m_d[i];
            rise[i] = all_diff && !m_d[i];
        end
        trig = 0; any_busy = 0;
        for (int i = 0; i < NB; i++) begin
            if (m_pressed[i]) any_busy = 1;
            n_other = 0;
            for (int j = 0; j < NB; j++) if (j != i && (m_pressed[j] || fall[j])) n_other++;
            if (fall[i] && n_other > 0) trig = 1;
        end
        supp = m_lock || trig;
        for (int i = 0; i < NB; i++) begin
            if (m_pressed[i]) begin
                if (rise[i]) begin
                    sset[i] = !m_long_done[i] && !supp;
                    m_pressed[i] = 0;
                end else if (!m_long_done[i] && m_age[i] == HOLD - 1) begin
                    lset[i] = !supp;
                    m_long_done[i] = 1;
                end
                m_age[i]++;
            end else if (fall[i]) begin
                m_pressed[i] = 1; m_age[i] = 0; m_long_done[i] = 0;
            end
        end
        m_lock = trig || (m_lock && any_busy);
        if (m_acc && !m_wr) begin
            if (m_addr == 0) sclr = m_short;
            if (m_addr == 1) lclr = m_long;
            if (m_addr == 2) cclr = m_combo;
        end else if (m_acc && m_wr) begin
            if (m_addr == 0) sclr = bus.HWDATA[NB-1:0];
            if (m_addr == 1) lclr = bus.HWDATA[NB-1:0];
            if (m_addr == 2) cclr = bus.HWDATA[0];
        end
        m_irq = ((|m_short) && m_en[0]) || ((|m_long) && m_en[1]) || (m_combo && m_en[2]);
`ifdef BTN_IRQ_EN
        if (m_acc && m_wr && m_addr == 4) m_en = bus.HWDATA[2:0];
`endif
        m_short = (m_short & ~sclr) | sset;
        m_long  = (m_long & ~lclr) | lset;
        m_combo = (m_combo && !cclr) || trig;
        m_d     = m_d ^ (fall | rise);
        m_acc   = bus.HSEL && bus.HREADY && bus.HTRANS != 2'b00;
        m_wr    = m_acc && bus.HWRITE;
        m_addr  = int'(bus.HADDR[4:2]);
        m_p1    = m_p0;
        m_p0    = nBtn;
    endtask

    function automatic logic [31:0] exp_rdata();
        logic [31:0] r;
        r = '0;
        if (m_acc && !m_wr) begin
            case (m_addr)
                0: r[NB-1:0] = m_short;
                1: r[NB-1:0] = m_long;
                2: r[0] = m_combo;
                3: begin
                    r[0] = (|m_short) | (|m_long) | m_combo;
                    r[8 +: NB] = ~m_d;
                end
`ifdef BTN_IRQ_EN
                4: r[2:0] = m_en;
`endif
                default: ;
            endcase
        end
        return r;
    endfunction

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) model_reset();
        else model_step();
    end

    always @(negedge HCLK) begin
        if (HRESETn && check_en) begin
            check("hrdata", bus.HRDATA, exp_rdata());
            check("hreadyout", 32'(bus.HREADYOUT), 32'd1);
`ifdef BTN_IRQ_EN
            check("irq", 32'(irq), 32'(m_irq));
`endif
        end
    end

    task automatic bus_idle();
        bus.HSEL = 0; bus.HTRANS = 2'b00; bus.HWRITE = 0; bus.HREADY = 1;
        bus.HSIZE = 3'b010; bus.HADDR = '0;
    endtask

    task automatic bus_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata);
        @(negedge HCLK);
        bus.HSEL = 1; bus.HTRANS = 2'b10; bus.HWRITE = wr; bus.HADDR = addr;
        @(negedge HCLK);
        bus_idle();
        bus.HWDATA = wdata;
        rdata = bus.HRDATA;
    endtask

    task automatic rd_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] v;
        bus_xfer(1'b0, addr, 32'h0, v);
        check(name, v, exp);
    endtask

    function automatic int pick_dur();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 3) return int'($urandom_range(1, 3));
        if (r < 8) return int'($urandom_range(5, 15));
        return int'($urandom_range(25, 45));
    endfunction

    initial begin
        logic [31:0] v;
        int dur [NB];
        HRESETn = 0; nBtn = '1; bus.HWDATA = '0;
        bus_idle();
        repeat (3) @(negedge HCLK);
        check("reset_hrdata", bus.HRDATA, 32'h0);
        HRESETn = 1;
        check_en = 1;
        rd_check("reset_status", 32'h0C, 32'h0);
        rd_check("reset_short", 32'h00, 32'h0);

        // Bounce shorter than the debounce window.
        nBtn[0] = 0; repeat (3) @(negedge HCLK);
        nBtn[0] = 1; repeat (2) @(negedge HCLK);
        nBtn[0] = 0; repeat (3) @(negedge HCLK);
        nBtn[0] = 1; repeat (8) @(negedge HCLK);
        rd_check("bounce_status", 32'h0C, 32'h0);

        // Short press, read-to-clear.
        nBtn[1] = 0; repeat (10) @(negedge HCLK);
        nBtn[1] = 1; repeat (10) @(negedge HCLK);
        rd_check("short_first", 32'h00, 32'h2);
        rd_check("short_second", 32'h00, 32'h0);
        rd_check("short_status", 32'h0C, 32'h0);

        // Long press.
        nBtn[2] = 0; repeat (30) @(negedge HCLK);
        rd_check("long_held_status", 32'h0C, 32'h401);
        rd_check("long_flag", 32'h04, 32'h4);
        repeat (8) @(negedge HCLK);
        nBtn[2] = 1; repeat (10) @(negedge HCLK);
        rd_check("long_no_short", 32'h00, 32'h0);
        rd_check("long_cleared", 32'h04, 32'h0);

        // Combo.
        nBtn[0] = 0; repeat (6) @(negedge HCLK);
        nBtn[1] = 0; repeat (8) @(negedge HCLK);
        nBtn = '1; repeat (10) @(negedge HCLK);
        rd_check("combo_flag", 32'h08, 32'h1);
        rd_check("combo_short", 32'h00, 32'h0);
        rd_check("combo_long", 32'h04, 32'h0);

        // W1C landing on the same edge as a new SHORT[0] set.
        nBtn[0] = 0; repeat (10) @(negedge HCLK);
        nBtn[0] = 1; repeat (3) @(negedge HCLK);
        bus_xfer(1'b1, 32'h00, 32'h1, v);
        rd_check("race_short", 32'h00, 32'h1);

        // Reset while PRESSED, released right after reset.
        nBtn[0] = 0; repeat (10) @(negedge HCLK);
        HRESETn = 0; repeat (2) @(negedge HCLK);
        HRESETn = 1; nBtn[0] = 1; repeat (12) @(negedge HCLK);
        rd_check("rst_short", 32'h00, 32'h0);
        rd_check("rst_long", 32'h04, 32'h0);
        rd_check("rst_combo", 32'h08, 32'h0);
        rd_check("rst_status", 32'h0C, 32'h0);
        rd_check("irq_en_rd", 32'h10, 32'h0);

`ifdef BTN_IRQ_EN
        bus_xfer(1'b1, 32'h10, 32'h1, v);
        rd_check("irq_en_val", 32'h10, 32'h1);
        nBtn[1] = 0; repeat (10) @(negedge HCLK);
        nBtn[1] = 1; repeat (10) @(negedge HCLK);
        check("irq_high", 32'(irq), 32'd1);
        rd_check("irq_short", 32'h00, 32'h2);
        repeat (2) @(negedge HCLK);
        check("irq_low", 32'(irq), 32'd0);
`endif

        // Random buttons and bus traffic.
        for (int i = 0; i < NB; i++) dur[i] = pick_dur();
        for (int c = 0; c < 4000; c++) begin
            @(negedge HCLK);
            for (int i = 0; i < NB; i++) begin
                dur[i]--;
                if (dur[i] <= 0) begin
                    nBtn[i] = ~nBtn[i];
                    dur[i] = pick_dur();
                end
            end
            bus.HWDATA = $urandom;
            if ($urandom_range(0, 2) == 0) begin
                bus.HSEL   = 1;
                bus.HTRANS = 2'($urandom_range(0, 3));
                bus.HWRITE = ($urandom_range(0, 6) == 0);
                bus.HREADY = ($urandom_range(0, 9) != 0);
                bus.HADDR  = $urandom;
                bus.HADDR[4:2] = 3'($urandom_range(0, 5));
                bus.HADDR[1:0] = 2'b00;
            end else begin
                bus_idle();
            end
        end
        bus_idle();
        repeat (5) @(negedge HCLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
